alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter SAT, default 0; 1 = saturate ADD/SUB results on overflow.
REQ-003 SHALL have parameter CNT_W, default 8, width of result counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of pipeline and counter.
REQ-007 SHALL have port in_valid  input  1  operands/opcode valid.
REQ-008 SHALL have port in_ready  output  1  block can accept input this cycle.
REQ-009 SHALL have port opcode  input  3  operation select.
REQ-010 SHALL have ports A, B  input  WIDTH each  signed operands.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port C  output  WIDTH+1  signed result.
REQ-014 SHALL have ports zero, neg, ovf  output  1 each  result flags.
REQ-015 SHALL have port done_cnt  output  CNT_W  count of results delivered.

Function
REQ-016 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 NOT ~A; 011 RED_OR |B; 100 AND; 101 XOR; 110 SHL; 111 ASR.
REQ-017 ADD/SUB/NOT/AND/XOR SHALL sign-extend operands to WIDTH+1 before computing; RED_OR result SHALL be zero-extended 1 bit.
REQ-018 SHL/ASR SHALL sign-extend A to WIDTH+1 and shift by unsigned B[clog2(WIDTH)-1:0]; ASR fills with sign bit, SHL fills with 0, bits shifted out discarded.
REQ-019 ovf SHALL be 1 only for ADD/SUB when the exact result lies outside the signed WIDTH-bit range; 0 for all other opcodes.
REQ-020 With SAT=1 and ovf=1, C SHALL be clamped to +(2^(WIDTH-1)-1) or -(2^(WIDTH-1)), sign-extended; ovf still reported 1.
REQ-021 zero SHALL equal (C==0) and neg SHALL equal C[WIDTH], both computed on the final (post-saturation) C.
REQ-022 Pipeline SHALL be two register stages: S1 captures inputs, S2 holds computed result and flags; C/flags driven from S2.
REQ-023 Input SHALL be accepted on a rising edge where in_valid && in_ready; latency to out_valid SHALL be exactly 2 cycles with no stall.
REQ-024 S2 SHALL advance when !out_valid || out_ready; S1 SHALL advance into S2 when S2 advances; in_ready SHALL be high when S1 empty or S1 advancing, and clear low.
REQ-025 Full throughput: with in_valid and out_ready held high, one result SHALL be delivered per cycle.
REQ-026 While out_valid && !out_ready, C, flags and out_valid SHALL hold stable; no data SHALL be lost or duplicated.
REQ-027 done_cnt SHALL increment by 1 on each edge with out_valid && out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-028 clear=1 SHALL on the next edge empty S1 and S2 (out_valid=0) and zero done_cnt; an input presented while clear=1 SHALL not be accepted; a handshake completing that same cycle SHALL not increment done_cnt.

Reset
REQ-029 rst_n=0 SHALL immediately, without clk, force out_valid=0, S1 empty, C=0, zero=0, neg=0, ovf=0, done_cnt=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after deassertion.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.

Verification (WIDTH=4 unless noted)
REQ-032 SAT=0: ADD A=7,B=7 -> two cycles later C=5'b01110, ovf=1, neg=0, zero=0; SAT=1 -> C=5'b00111, ovf=1.
REQ-033 SUB A=-8,B=1 -> C=5'b10111, ovf=1, neg=1; SAT=1 -> C=5'b11000.
REQ-034 ASR A=-8,B=2 -> C=5'b11110; SHL A=3,B=2 -> C=5'b01100; RED_OR B=0 -> C=0, zero=1.
REQ-035 Stream 6 ops with out_ready low for 3 cycles mid-stream -> in_ready drops, all 6 results delivered in order, done_cnt=6.
REQ-036 Assert rst_n=0 between edges with 2 ops in flight -> outputs zero immediately, no results after release, done_cnt=0.
REQ-037 clear=1 for one cycle with 2 ops in flight and done_cnt=3 -> out_valid=0 and done_cnt=0 next cycle, input that cycle not accepted.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU.
// Stage S1 registers the operands and opcode. Stage S2 registers the result and flags.
// C and the flags are driven straight from S2.
// done_cnt counts the results that are accepted downstream.
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int SAT   = 0,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     C,
  output logic               zero,
  output logic               neg,
  output logic               ovf,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam int SH_W = $clog2(WIDTH);

  // Clamp values for saturating ADD/SUB, already sign-extended to WIDTH+1 bits.
  localparam logic [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0] SAT_MIN = {2'b11, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_NOT    = 3'b010,
    OP_RED_OR = 3'b011,
    OP_AND    = 3'b100,
    OP_XOR    = 3'b101,
    OP_SHL    = 3'b110,
    OP_ASR    = 3'b111
  } op_e;

  // S1: captured operands
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  // S2: result and flags
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   c_q, c_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  // Datapath signals computed from S1
  logic signed [WIDTH:0] a_ext, b_ext, raw;
  logic [SH_W-1:0]       sh_amt;
  logic                  arith;
  logic                  res_ovf;
  logic [WIDTH:0]        res_c;

  logic s2_adv;

  // Handshake. S2 moves when it is empty or being drained. S1 moves whenever S2 moves.
  // in_ready is held low during reset and during clear.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = rst_n && !clear && (!s1_valid_q || s2_adv);
  end

  // Compute the ALU result and the overflow flag from the S1 contents.
  // Saturation is applied to the result when SAT is set.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    a_ext  = {s1_a_q[WIDTH-1], s1_a_q};
    b_ext  = {s1_b_q[WIDTH-1], s1_b_q};
    sh_amt = s1_b_q[SH_W-1:0];
    raw    = '0;
    arith  = 1'b0;
    case (s1_op_q)
      OP_ADD:    begin raw = a_ext + b_ext; arith = 1'b1; end
      OP_SUB:    begin raw = a_ext - b_ext; arith = 1'b1; end
      OP_NOT:    raw = ~a_ext;
      OP_RED_OR: raw = {{WIDTH{1'b0}}, |s1_b_q};
      OP_AND:    raw = a_ext & b_ext;
      OP_XOR:    raw = a_ext ^ b_ext;
      OP_SHL:    raw = a_ext <<< sh_amt;
      OP_ASR:    raw = a_ext >>> sh_amt;
      default:   raw = '0;
    endcase
    // The WIDTH+1-bit sum is exact. The top two bits disagree only when the result
    // is outside the signed WIDTH-bit range.
    res_ovf = arith && (raw[WIDTH] != raw[WIDTH-1]);
    res_c   = raw;
    if ((SAT != 0) && res_ovf) begin
      res_c = raw[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Next state for both stages and for the delivery counter.
  // A clear overrides every other update.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    done_cnt_d  = done_cnt_q;

    if (clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      c_d         = '0;
      zero_d      = 1'b0;
      neg_d       = 1'b0;
      ovf_d       = 1'b0;
      done_cnt_d  = '0;
    end else begin
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_op_d = op_e'(opcode);
          s1_a_d  = A;
          s1_b_d  = B;
        end
      end
      if (s2_adv) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          c_d    = res_c;
          zero_d = (res_c == '0);
          neg_d  = res_c[WIDTH];
          ovf_d  = res_ovf;
        end
      end
      if (out_valid_q && out_ready) begin
        done_cnt_d = done_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers. Reset is asynchronous and discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign C         = c_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: drives the same stimulus into two alu_pipe instances, one with SAT=0 and one with SAT=1.
// Every delivered result is compared against an integer-arithmetic reference model.
module tb_alu_pipe;

  localparam int W   = 4;
  localparam int SHW = $clog2(W);
  localparam int CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    opcode = 3'd0;
  logic [W-1:0]  a_in = '0, b_in = '0;

  logic          in_ready0, out_valid0, zero0, neg0, ovf0;
  logic [W:0]    c0;
  logic [CW-1:0] done0;
  logic          in_ready1, out_valid1, zero1, neg1, ovf1;
  logic [W:0]    c1;
  logic [CW-1:0] done1;

  alu_pipe #(.WIDTH(W), .SAT(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .opcode(opcode), .A(a_in), .B(b_in), .out_valid(out_valid0), .out_ready(out_ready),
    .C(c0), .zero(zero0), .neg(neg0), .ovf(ovf0), .done_cnt(done0)
  );

  alu_pipe #(.WIDTH(W), .SAT(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .opcode(opcode), .A(a_in), .B(b_in), .out_valid(out_valid1), .out_ready(out_ready),
    .C(c1), .zero(zero1), .neg(neg1), .ovf(ovf1), .done_cnt(done1)
  );

  typedef struct { logic [2:0] op; int a; int b; } txn_t;
  typedef struct { logic [W:0] c; logic zero; logic neg; logic ovf; } res_t;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_done = 0;

  // values sampled by step()
  logic       s_ir, s_ov, s_acc, s_dlv;
  logic [W:0] last_c0, last_c1;
  logic [2:0] last_f0, last_f1;
  logic       prev_stall = 1'b0;
  logic [W:0] prev_c0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: signed integer arithmetic, reduced to WIDTH+1 bits only at the end.
  function automatic res_t model(input logic [2:0] op, input int a, input int b, input bit sat);
    int lo, hi, r, sh;
    res_t res;
    logic [W:0] cv;
    lo = -(2 ** (W - 1));
    hi = 2 ** (W - 1) - 1;
    sh = b & ((1 << SHW) - 1);
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = -a - 1;
      3'd3:    r = (b != 0) ? 1 : 0;
      3'd4:    r = a & b;
      3'd5:    r = a ^ b;
      3'd6:    r = a * (1 << sh);
      default: r = a >>> sh;
    endcase
    res.ovf = (op <= 3'd1) && (r < lo || r > hi);
    if (sat && res.ovf) r = (r > hi) ? hi : lo;
    cv       = r[W:0];
    res.c    = cv;
    res.zero = (cv == '0);
    res.neg  = cv[W];
    return res;
  endfunction

  // One clock cycle. The caller sets the inputs at a negedge.
  // Outputs are sampled 1 time unit before the next posedge, and the task returns at the following negedge.
  task automatic step();
    txn_t t;
    res_t r0, r1;
    #4;
    s_ir  = in_ready0;
    s_ov  = out_valid0;
    s_acc = in_valid && in_ready0;
    s_dlv = 1'b0;
    check("done_cnt", done0, exp_done);
    if (prev_stall) begin
      check("stall_hold_valid", out_valid0, 1'b1);
      check("stall_hold_c", c0, prev_c0);
    end
    prev_stall = out_valid0 && !out_ready && !clear;
    prev_c0    = c0;
    if (out_valid0 && out_ready && !clear) begin
      s_dlv = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else begin
        t  = exp_q.pop_front();
        r0 = model(t.op, t.a, t.b, 1'b0);
        r1 = model(t.op, t.a, t.b, 1'b1);
        check("c_sat0", c0, r0.c);
        check("flags_sat0", {zero0, neg0, ovf0}, {r0.zero, r0.neg, r0.ovf});
        check("valid_sat1", out_valid1, 1'b1);
        check("c_sat1", c1, r1.c);
        check("flags_sat1", {zero1, neg1, ovf1}, {r1.zero, r1.neg, r1.ovf});
        last_c0  = c0;
        last_c1  = c1;
        last_f0  = {zero0, neg0, ovf0};
        last_f1  = {zero1, neg1, ovf1};
        exp_done = (exp_done + 1) % (2 ** CW);
      end
    end
    if (s_acc) exp_q.push_back('{opcode, int'($signed(a_in)), int'($signed(b_in))});
    if (clear) begin
      exp_q.delete();
      exp_done = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {out_valid0, out_valid1}, 2'b00);
    check({tag, "_c"}, {c0, c1}, '0);
    check({tag, "_flags"}, {zero0, neg0, ovf0, zero1, neg1, ovf1}, 6'b0);
    check({tag, "_done"}, {done0, done1}, '0);
    check({tag, "_in_ready"}, {in_ready0, in_ready1}, 2'b00);
  endtask

  // Reset is asserted at a negedge and released at a later negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done = 0;
    prev_stall = 1'b0;
  endtask

  // A single op into an idle pipe. The result must appear exactly two edges after acceptance.
  task automatic single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    opcode = op; a_in = a; b_in = b;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("single_accept", s_ir, 1'b1);
    in_valid = 1'b0;
    step();
    check("latency_1_no_valid", s_ov, 1'b0);
    step();
    check("latency_2_valid", s_ov, 1'b1);
  endtask

  task automatic rand_inputs();
    opcode = 3'($urandom);
    a_in   = W'($urandom);
    b_in   = W'($urandom);
  endtask

  task automatic drain(input string tag);
    int cyc;
    in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_dlv, cyc;
    logic saw_low;

    // Asynchronous reset takes effect with no clock edge in between.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", s_ir, 1'b1);

    // Directed vectors for overflow, saturation, shifts and the zero flag.
    single(3'd0, 4'd7, 4'd7);
    check("add77_c", last_c0, 5'b01110);
    check("add77_f", last_f0, 3'b001);
    check("add77_sat_c", last_c1, 5'b00111);
    check("add77_sat_f", last_f1, 3'b001);
    single(3'd1, 4'h8, 4'd1);
    check("sub_m8_1_c", last_c0, 5'b10111);
    check("sub_m8_1_f", last_f0, 3'b011);
    check("sub_m8_1_sat_c", last_c1, 5'b11000);
    single(3'd7, 4'h8, 4'd2);
    check("asr_m8_2_c", last_c0, 5'b11110);
    single(3'd6, 4'd3, 4'd2);
    check("shl_3_2_c", last_c0, 5'b01100);
    single(3'd3, 4'd5, 4'd0);
    check("redor_0_c", last_c0, 5'b00000);
    check("redor_0_f", last_f0, 3'b100);

    // Stream of six ops with out_ready low for three cycles in the middle.
    do_reset();
    n_acc = 0; n_dlv = 0; cyc = 0; saw_low = 1'b0;
    while ((n_acc < 6 || exp_q.size() > 0) && cyc < 60) begin
      in_valid  = (n_acc < 6);
      rand_inputs();
      out_ready = !(cyc >= 3 && cyc < 6);
      step();
      if (s_acc) n_acc++;
      if (s_dlv) n_dlv++;
      if (!s_ir) saw_low = 1'b1;
      cyc++;
    end
    check("stream_in_time", cyc < 60, 1'b1);
    check("stream_in_ready_dropped", saw_low, 1'b1);
    check("stream_delivered", n_dlv, 6);
    check("stream_done_cnt", done0, 8'd6);

    // Clear with two ops in flight after three deliveries.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      single(opcode, a_in, b_in);
    end
    check("pre_clear_done", done0, 8'd3);
    in_valid = 1'b1; out_ready = 1'b1;
    rand_inputs(); step();
    rand_inputs(); step();
    clear = 1'b1;
    rand_inputs();
    step();
    check("clear_in_ready_low", s_ir, 1'b0);
    check("clear_two_in_flight", s_ov, 1'b1);
    clear = 1'b0; in_valid = 1'b0;
    step();
    check("after_clear_valid", s_ov, 1'b0);
    check("after_clear_done", done0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_clear_idle", s_ov, 1'b0);
    end

    // Reset asserted between clock edges while two ops are in flight.
    single(3'd0, 4'd1, 4'd2);
    in_valid = 1'b1; out_ready = 1'b1;
    rand_inputs(); step();
    rand_inputs(); step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midop_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_no_output", s_ov, 1'b0);
    end

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 49) == 0);
      rand_inputs();
      step();
    end
    drain("random");

    // Full throughput. done_cnt runs past 255 and wraps.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
      if (i >= 2) check("throughput_valid", s_ov, 1'b1);
      check("throughput_ready", s_ir, 1'b1);
    end
    drain("throughput");
    check("wrap_done_cnt", done0, 8'((300) % 256));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
